// File: rtl/lab5_period_meter.sv
// Rise-to-rise period meter for a slow square wave on sig_in, with loss-of-signal flag.
// Optional frequency-lock detector enabled by defining LOCK_DETECT_EN.
module lab5_period_meter #(
  parameter int CNT_W         = 16,
  parameter int EXPECT_PERIOD = 8,
  parameter int TOLERANCE     = 0,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_LOST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // r_sync[0]/[1] form the synchroniser, r_sync[2] delays s2 for edge detection
  logic [2:0]       r_sync;
  logic             w_rise;

  state_t           r_state;
  state_t           w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;

  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_period_next;
  logic             w_valid_next;
  logic             w_timeout_next;
  logic             w_cnt_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], sig_in};
    end
  end

  assign w_rise    = r_sync[1] & ~r_sync[2];
  assign w_cnt_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_rise) w_state_next = S_MEAS;
      S_MEAS: if (!w_rise && w_cnt_max) w_state_next = S_LOST;
      S_LOST: if (w_rise) w_state_next = S_MEAS;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A rise coinciding with a saturated counter is still a valid measurement
  always_comb begin
    w_cnt_next     = r_cnt;
    w_period_next  = r_period;
    w_valid_next   = 1'b0;
    w_timeout_next = r_timeout;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = w_rise ? CNT_W'(1) : '0;
      end
      S_MEAS: begin
        if (w_rise) begin
          w_period_next = r_cnt;
          w_valid_next  = 1'b1;
          w_cnt_next    = CNT_W'(1);
        end else if (w_cnt_max) begin
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_LOST: begin
        w_timeout_next = 1'b1;
        if (w_rise) begin
          w_cnt_next     = CNT_W'(1);
          w_timeout_next = 1'b0;
        end
      end
      default: begin
        w_cnt_next     = '0;
        w_timeout_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_period  <= w_period_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;

`ifdef LOCK_DETECT_EN
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int DIFF_W  = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]   EXP_V     = CNT_W'(EXPECT_PERIOD);
  localparam logic [DIFF_W-1:0]  TOL_V     = DIFF_W'(TOLERANCE);

  logic [MATCH_W-1:0] r_match_cnt;
  logic               r_locked;
  logic [MATCH_W-1:0] w_match_next;
  logic [DIFF_W-1:0]  w_diff;
  logic               w_match;
  logic               w_lost_entry;

  // Compare the value being captured into period (r_cnt) so locked updates with the valid
  assign w_diff       = (r_cnt >= EXP_V) ? DIFF_W'(r_cnt - EXP_V) : DIFF_W'(EXP_V - r_cnt);
  assign w_match      = (w_diff <= TOL_V);
  assign w_lost_entry = (r_state == S_MEAS) && (w_state_next == S_LOST);

  always_comb begin
    w_match_next = r_match_cnt;
    if (w_lost_entry) begin
      w_match_next = '0;
    end else if (w_valid_next) begin
      if (!w_match) begin
        w_match_next = '0;
      end else if (r_match_cnt != MATCH_TOP) begin
        w_match_next = r_match_cnt + MATCH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_match_cnt <= w_match_next;
      r_locked    <= (w_match_next == MATCH_TOP);
    end
  end

  assign locked = r_locked;
`else
  // Lock parameters only matter when the detector is built; keep them referenced
  localparam bit LOCK_CFG_OK = (LOCK_COUNT >= 1) && (TOLERANCE >= 0) && (EXPECT_PERIOD >= 0);

  assign locked = 1'b0 && LOCK_CFG_OK;
`endif

endmodule

// File: tb/tb_lab5_period_meter.sv
// Randomised scoreboard bench for lab5_period_meter: stimulus pushes expected valids and
// timeout transitions (indexed by falling clk edge), a monitor pops and compares them.
module tb_lab5_period_meter;

  localparam int CNT_W  = 5;
  localparam int EXP_P  = 8;
  localparam int TOL    = 1;
  localparam int LOCK_N = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             locked;

  lab5_period_meter #(
    .CNT_W(CNT_W), .EXPECT_PERIOD(EXP_P), .TOLERANCE(TOL), .LOCK_COUNT(LOCK_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .period(period),
    .period_valid(period_valid), .timeout(timeout), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int per; bit lck; } vev_t;
  typedef struct { int idx; bit lvl; } tev_t;

  vev_t vq[$];
  tev_t tq[$];
  int   checks = 0;
  int   failures = 0;
  int   neg_cnt = 0;
  bit   in_reset = 1'b1;

  // Reference model state: time of last rise, whether a reference exists, match streak
  bit   have_ref = 1'b0;
  int   last_rise = 0;
  int   match_run = 0;

  always @(negedge clk) neg_cnt <= neg_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; the rise is seen by the DUT three rising edges later
  task automatic do_rise(input int next_gap);
    int k;
    int gap;
    int d;
    k = neg_cnt;
    if (have_ref) begin
      gap = k - last_rise;
      if (gap <= CMAX) begin
        d = (gap > EXP_P) ? gap - EXP_P : EXP_P - gap;
        if (d <= TOL) match_run = (match_run < LOCK_N) ? match_run + 1 : LOCK_N;
        else match_run = 0;
        vq.push_back('{idx: k + 3, per: gap, lck: LOCK_EN && (match_run == LOCK_N)});
      end else begin
        tq.push_back('{idx: k + 3, lvl: 1'b0});
      end
    end
    sig_in = 1'b1;
    last_rise = k;
    have_ref = 1'b1;
    if (next_gap > CMAX) begin
      tq.push_back('{idx: k + 3 + CMAX, lvl: 1'b1});
      match_run = 0;
    end
  endtask

  task automatic do_seg(input int g);
    int h;
    h = $urandom_range(1, g - 1);
    do_rise(g);
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (g - h) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_locked"}, locked, 0);
  endtask

  task automatic reset_mid();
    do_rise(0);
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    vq.delete();
    tq.delete();
    have_ref = 1'b0;
    match_run = 0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT presents a valid or moves timeout
  initial begin
    bit   prev_to;
    int   last_per;
    int   idx;
    vev_t ve;
    tev_t te;
    prev_to = 1'b0;
    last_per = 0;
    forever begin
      @(negedge clk);
      idx = neg_cnt;
      if (in_reset) begin
        prev_to = timeout;
        last_per = 0;
        continue;
      end
      if (period_valid) begin
        if (vq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          ve = vq.pop_front();
          check("valid_time", idx, ve.idx);
          check("period", period, ve.per);
          check("locked", locked, ve.lck);
          last_per = ve.per;
        end
      end
      if (timeout !== prev_to) begin
        if (tq.size() == 0) begin
          check("unexpected_timeout_change", timeout, prev_to);
        end else begin
          te = tq.pop_front();
          check("timeout_time", idx, te.idx);
          check("timeout_level", timeout, te.lvl);
          if (timeout) begin
            check("period_hold_on_timeout", period, last_per);
            check("locked_on_timeout", locked, 0);
          end
        end
      end
      prev_to = timeout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int g;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #2;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    repeat (6) do_seg(8);
    repeat (3) do_seg(10);
    repeat (4) begin
      do_seg(7);
      do_seg(9);
    end
    do_seg(CMAX);
    do_seg(CMAX + 1);
    do_seg(45);
    do_seg(8);
    do_seg(2);
    do_seg(2);

    reset_mid();
    do_seg(8);
    do_seg(8);
    do_seg(12);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) g = $urandom_range(CMAX, CMAX + 15);
      else if (r < 5) g = $urandom_range(7, 9);
      else g = $urandom_range(2, 20);
      do_seg(g);
    end
    do_rise(0);
    repeat (12) @(negedge clk);

    check("valid_queue_drained", vq.size(), 0);
    check("timeout_queue_drained", tq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
